// File: rtl/wb_initiator_bridge_if.sv
// Command/response and Wishbone bus bundle for wb_initiator_bridge.
// WBM_ERR_EN adds the wbm_err_i error-termination input.
interface wb_initiator_bridge_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
`ifdef WBM_ERR_EN
    logic        wbm_err_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wbm_dat_i, wbm_ack_i, wbm_err_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
`else
    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wbm_dat_i, wbm_ack_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wbm_dat_i, wbm_ack_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
`endif
endinterface

// File: rtl/wb_initiator_bridge.sv
// Single-beat Wishbone B4 classic initiator: valid/ready command in, data/error response out.
// Optional WBM_ERR_EN: wbm_err_i terminates a cycle with an error response.
module wb_initiator_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    wb_initiator_bridge_if.master  bus
);

    localparam int unsigned     CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             bus_err;

`ifdef WBM_ERR_EN
    assign bus_err = bus.wbm_err_i;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_dat   <= '0;
            bus.rsp_err   <= 1'b0;
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.wbm_we_o  <= 1'b0;
            bus.wbm_sel_o <= '0;
            bus.wbm_adr_o <= '0;
            bus.wbm_dat_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        bus.wbm_cyc_o <= 1'b1;
                        bus.wbm_stb_o <= 1'b1;
                        bus.wbm_we_o  <= bus.cmd_we;
                        bus.wbm_sel_o <= bus.cmd_sel;
                        bus.wbm_adr_o <= bus.cmd_adr;
                        bus.wbm_dat_o <= bus.cmd_dat;
                        cnt           <= '0;
                        state         <= BUS;
                    end
                end
                BUS: begin
                    // Priority err > ack > timeout: a late ack still beats the abort.
                    if (bus_err) begin
                        bus.wbm_cyc_o <= 1'b0;
                        bus.wbm_stb_o <= 1'b0;
                        bus.rsp_dat   <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else if (bus.wbm_ack_i) begin
                        bus.wbm_cyc_o <= 1'b0;
                        bus.wbm_stb_o <= 1'b0;
                        bus.rsp_dat   <= bus.wbm_we_o ? '0 : bus.wbm_dat_i;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
                        bus.wbm_cyc_o <= 1'b0;
                        bus.wbm_stb_o <= 1'b0;
                        bus.rsp_dat   <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator_bridge.sv
// Scoreboard bench for wb_initiator_bridge (TIMEOUT_CYCLES=16); err cases built with WBM_ERR_EN.
module tb_wb_initiator_bridge;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [32:0] exp_q[$];

    wb_initiator_bridge_if bus();

    wb_initiator_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got time-limit expiry, required test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got dat 0x%08h err %0b, required no response",
                         bus.rsp_dat, bus.rsp_err);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("rsp_dat", bus.rsp_dat, e[31:0]);
                check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e[32]});
            end
        end
    end

    task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int ack_wait, input logic drv_ack,
                          input logic drv_err, input logic [31:0] rdata,
                          input logic [31:0] exp_dat, input logic exp_err, input int exp_stb);
        int guard;
        int stb_cycles;
        guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_wait", {31'b0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        exp_q.push_back({exp_err, exp_dat});
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = ~we;
        bus.cmd_adr   = ~adr;
        bus.cmd_dat   = ~dat;
        bus.cmd_sel   = ~sel;
        stb_cycles = 0;
        guard = 0;
        @(negedge clk);
        while (bus.wbm_stb_o && guard < 100) begin
            stb_cycles++;
            if (stb_cycles == 1) begin
                check("wbm_cyc", {31'b0, bus.wbm_cyc_o}, 32'd1);
                check("wbm_we",  {31'b0, bus.wbm_we_o}, {31'b0, we});
                check("wbm_adr", bus.wbm_adr_o, adr);
                check("wbm_dat", bus.wbm_dat_o, dat);
                check("wbm_sel", {28'b0, bus.wbm_sel_o}, {28'b0, sel});
                check("cmd_ready_busy", {31'b0, bus.cmd_ready}, 32'd0);
            end
            if (ack_wait >= 0 && stb_cycles == ack_wait + 1) begin
                bus.wbm_ack_i = drv_ack;
`ifdef WBM_ERR_EN
                bus.wbm_err_i = drv_err;
`endif
                bus.wbm_dat_i = rdata;
            end
            @(posedge clk);
            #1;
            bus.wbm_ack_i = 1'b0;
`ifdef WBM_ERR_EN
            bus.wbm_err_i = 1'b0;
`endif
            bus.wbm_dat_i = 32'hDEAD_BEEF;
            @(negedge clk);
            guard++;
        end
        check("stb_cycles", stb_cycles, exp_stb);
        check("cyc_after", {31'b0, bus.wbm_cyc_o}, 32'd0);
        check("rsp_valid_latency", {31'b0, bus.rsp_valid}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_dat   = '0;
        bus.cmd_sel   = '0;
        bus.rsp_ready = 1'b1;
        bus.wbm_dat_i = 32'hDEAD_BEEF;
        bus.wbm_ack_i = 1'b0;
`ifdef WBM_ERR_EN
        bus.wbm_err_i = 1'b0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_dat",   bus.rsp_dat, 32'd0);
        check("rst_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
        check("rst_cyc_stb",   {30'b0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd0);
        check("rst_we",        {31'b0, bus.wbm_we_o}, 32'd0);
        check("rst_sel",       {28'b0, bus.wbm_sel_o}, 32'd0);
        check("rst_adr",       bus.wbm_adr_o, 32'd0);
        check("rst_dat",       bus.wbm_dat_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_idle_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);

        // Write, ack on third stb cycle; read data on the bus must not leak into rsp_dat
        do_cmd(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2, 1'b1, 1'b0, 32'h5555_AAAA,
               32'h0, 1'b0, 3);

        // Read, zero-wait ack
        do_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'hCAFE_F00D,
               32'hCAFE_F00D, 1'b0, 1);

        // Read with partial byte lanes
        do_cmd(1'b0, 32'h3000_0010, 32'h0, 4'h3, 4, 1'b1, 1'b0, 32'h0000_BEEF,
               32'h0000_BEEF, 1'b0, 5);

        // Timeout: no ack, stb for exactly 16 cycles
        do_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF, -1, 1'b0, 1'b0, 32'h0,
               32'h0, 1'b1, 16);

        // Ack on the final timeout cycle wins
        do_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF, 15, 1'b1, 1'b0, 32'h1357_9BDF,
               32'h1357_9BDF, 1'b0, 16);

        // Backpressure: response held for 10 cycles
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        do_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h1234_5678,
               32'h1234_5678, 1'b0, 2);
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            check("bp_rsp_dat",   bus.rsp_dat, 32'h1234_5678);
            check("bp_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_cmd_ready_after", {31'b0, bus.cmd_ready}, 32'd1);
        check("bp_rsp_valid_after", {31'b0, bus.rsp_valid}, 32'd0);

        // Stray ack in IDLE changes nothing
        bus.wbm_ack_i = 1'b1;
        @(posedge clk);
        #1;
        bus.wbm_ack_i = 1'b0;
        @(negedge clk);
        check("stray_ack_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        check("stray_ack_cyc",       {31'b0, bus.wbm_cyc_o}, 32'd0);
        check("stray_ack_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);

        // Reset while stb is high: cycle drops at once, no response afterwards
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h3000_0030;
        bus.cmd_sel   = 4'hF;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_stb_before", {31'b0, bus.wbm_stb_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_cyc_stb", {30'b0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd0);
        check("midrst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        end
        do_cmd(1'b0, 32'h3000_0034, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h0BAD_F00D,
               32'h0BAD_F00D, 1'b0, 2);

`ifdef WBM_ERR_EN
        // err on third stb cycle
        do_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF, 2, 1'b0, 1'b1, 32'h7777_7777,
               32'h0, 1'b1, 3);
        // ack and err together: err wins
        do_cmd(1'b1, 32'h3000_0044, 32'h1111_2222, 4'hF, 0, 1'b1, 1'b1, 32'h7777_7777,
               32'h0, 1'b1, 1);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
